// File: rtl/coin_seq_pkg.sv
// Shared definitions for the coin dispense sequencer: state encoding,
// servo direction levels and a constant-width helper.
package coin_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_PUSH        = 3'd1;
  localparam state_t ST_PUSH_WAIT   = 3'd2;
  localparam state_t ST_RETURN      = 3'd3;
  localparam state_t ST_RETURN_WAIT = 3'd4;
  localparam state_t ST_SETTLE      = 3'd5;
  localparam state_t ST_ERR         = 3'd6;
  localparam state_t ST_FINISH      = 3'd7;

  localparam logic SERVO_BACK  = 1'b1;
  localparam logic SERVO_FRONT = 1'b0;

  // Bits needed to represent values 0..value-1 (minimum 1).
  function automatic int clog2(input longint unsigned value);
    int w;
    w = 0;
    while ((64'd1 << w) < value) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter that saturates at zero; one instance paces every
// wait in the sequencer.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = value;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/coin_dispense_sequencer.sv
// Coin-pusher servo sequencer: one back/front stroke per requested coin.
// Optional abort input enabled by defining COIN_ABORT_EN.
module coin_dispense_sequencer
  import coin_seq_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int ACK_CYCLES = 16,
  parameter int STROKE_MAX = 40_000_000,
  parameter int SETTLE     = 1_000_000
) (
  input  logic             clk,
  input  logic             clr,
`ifdef COIN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_count,
  output logic             req_ready,
  output logic [31:0]      servo_ctrl,
  input  logic             servo_back_done,
  input  logic             servo_front_done,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] dispensed
);

  localparam int TMR_W = clog2(longint'(STROKE_MAX) + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] dispensed_q, dispensed_d;
  logic             servo_q, servo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             ready_q, ready_d;
  logic             tmr_load, tmr_zero;
  logic [TMR_W-1:0] tmr_value;
  logic             abort_pend;

`ifdef COIN_ABORT_EN
  logic abort_q, abort_d;

  // An abort during a stroke is remembered so the coin in flight still completes.
  always_comb begin
    abort_d = abort_q;
    if (state_q == ST_IDLE)
      abort_d = 1'b0;
    else if (abort && (state_q inside {ST_PUSH, ST_PUSH_WAIT, ST_RETURN, ST_RETURN_WAIT}))
      abort_d = 1'b1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) abort_q <= 1'b0;
    else      abort_q <= abort_d;
  end

  assign abort_pend = abort_q | abort;
`else
  assign abort_pend = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (req_valid) state_d = (req_count == '0) ? ST_FINISH : ST_PUSH;
      ST_PUSH:        if (!servo_back_done) state_d = ST_PUSH_WAIT;
                      else if (tmr_zero)    state_d = ST_ERR;
      ST_PUSH_WAIT:   if (servo_back_done)  state_d = ST_RETURN;
                      else if (tmr_zero)    state_d = ST_ERR;
      ST_RETURN:      if (!servo_front_done) state_d = ST_RETURN_WAIT;
                      else if (tmr_zero)     state_d = ST_ERR;
      ST_RETURN_WAIT: if (servo_front_done) state_d = abort_pend ? ST_FINISH : ST_SETTLE;
                      else if (tmr_zero)    state_d = ST_ERR;
      ST_SETTLE:      if (abort_pend)    state_d = ST_FINISH;
                      else if (tmr_zero) state_d = (remaining_q != '0) ? ST_PUSH : ST_FINISH;
      ST_ERR:         state_d = ST_FINISH;
      ST_FINISH:      state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // Timer reloads on every state entry with that state's wait budget.
  assign tmr_load = (state_d != state_q);

  always_comb begin
    tmr_value = '0;
    case (state_d)
      ST_PUSH, ST_RETURN:           tmr_value = TMR_W'(ACK_CYCLES - 1);
      ST_PUSH_WAIT, ST_RETURN_WAIT: tmr_value = TMR_W'(STROKE_MAX - 1);
      ST_SETTLE:                    tmr_value = TMR_W'(SETTLE - 1);
      default:                      tmr_value = '0;
    endcase
  end

  seq_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .clr   (clr),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  always_comb begin
    remaining_d = remaining_q;
    dispensed_d = dispensed_q;
    error_d     = error_q;
    if (state_q == ST_IDLE && req_valid) begin
      remaining_d = req_count;
      dispensed_d = '0;
      error_d     = 1'b0;
    end
    if (state_q == ST_RETURN_WAIT && servo_front_done) begin
      remaining_d = remaining_q - CNT_W'(1);
      dispensed_d = dispensed_q + CNT_W'(1);
    end
    if (state_d == ST_ERR) error_d = 1'b1;
    servo_d = (state_d == ST_PUSH || state_d == ST_PUSH_WAIT) ? SERVO_BACK : SERVO_FRONT;
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_q == ST_FINISH);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      remaining_q <= '0;
      dispensed_q <= '0;
      servo_q     <= SERVO_FRONT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      remaining_q <= remaining_d;
      dispensed_q <= dispensed_d;
      servo_q     <= servo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ready_q     <= ready_d;
    end
  end

  assign servo_ctrl = {31'b0, servo_q};
  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign dispensed  = dispensed_q;

endmodule

// File: tb/tb_coin_dispense_sequencer.sv
// Self-checking bench for coin_dispense_sequencer with a behavioural servo
// model and a request-level reference model.
module tb_coin_dispense_sequencer;

  localparam int CNT_W = 8;
  localparam int ACK   = 16;
  localparam int SMAX  = 300;
  localparam int SET   = 10;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic             req_valid = 1'b0;
  logic [CNT_W-1:0] req_count = '0;
  logic             req_ready;
  logic [31:0]      servo_ctrl;
  logic             servo_back_done = 1'b1;
  logic             servo_front_done = 1'b1;
  logic             busy, done, error;
  logic [CNT_W-1:0] dispensed;
`ifdef COIN_ABORT_EN
  logic             abort = 1'b0;
  int               abort_coin = 0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  coin_dispense_sequencer #(
    .CNT_W(CNT_W), .ACK_CYCLES(ACK), .STROKE_MAX(SMAX), .SETTLE(SET)
  ) dut (
    .clk              (clk),
    .clr              (clr),
`ifdef COIN_ABORT_EN
    .abort            (abort),
`endif
    .req_valid        (req_valid),
    .req_count        (req_count),
    .req_ready        (req_ready),
    .servo_ctrl       (servo_ctrl),
    .servo_back_done  (servo_back_done),
    .servo_front_done (servo_front_done),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .dispensed        (dispensed)
  );

  // Servo model: flag falls ~2 cycles after a ctrl edge and rises 100 cycles later.
  // fault_kind 1: back stroke of coin fault_coin never acknowledged.
  // fault_kind 2: front flag of coin fault_coin stuck low forever.
  int   bt = -1, ft = -1, back_edges = 0, front_edges = 0;
  int   fault_kind = 0, fault_coin = 0;
  bit   front_stuck = 0, model_clear = 0;
  logic prev_bit = 1'b0;

  always @(posedge clk) begin
    if (model_clear) begin
      bt = -1; ft = -1; back_edges = 0; front_edges = 0; front_stuck = 0;
    end else begin
      if (servo_ctrl[0] && !prev_bit) begin
        back_edges++;
        if (!(fault_kind == 1 && back_edges == fault_coin)) bt = 0;
      end
      if (!servo_ctrl[0] && prev_bit) begin
        front_edges++;
        ft = 0;
        front_stuck = (fault_kind == 2 && front_edges == fault_coin);
      end
      if (bt >= 0 && bt < 102) bt++;
      if (ft >= 0 && ft < 102 && !(front_stuck && ft >= 2)) ft++;
    end
    prev_bit = servo_ctrl[0];
    servo_back_done  <= !(bt >= 2 && bt < 102);
    servo_front_done <= !(ft >= 2 && ft < 102);
  end

`ifdef COIN_ABORT_EN
  always @(posedge clk)
    abort <= (abort_coin != 0 && back_edges == abort_coin && bt == 30);
`endif

  // Request-level reference: kinds 1/2 fail on coin `coin`, kind 3 aborts during coin `coin`.
  function automatic void ref_model(input int n, input int kind, input int coin,
                                    output int disp, output int err, output int pushes);
    disp = n; err = 0; pushes = n;
    if (n == 0) begin
      disp = 0; pushes = 0;
    end else if ((kind == 1 || kind == 2) && coin >= 1 && coin <= n) begin
      disp = coin - 1; err = 1; pushes = coin;
    end else if (kind == 3 && coin >= 1 && coin <= n) begin
      disp = coin; pushes = coin;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic recover();
    model_clear = 1; step(); model_clear = 0;
    fault_kind = 0; fault_coin = 0;
    repeat (5) step();
  endtask

  task automatic run_req(input int n, input bit noise,
                         output int disp, output int err, output int pushes,
                         output int pulses, output int lat, output bit timed_out,
                         output bit upper_ok, output bit first_back,
                         output bit busy_at_done, output bit ready_at_done);
    int cyc;
    bit seen, prev;
    for (int i = 0; i < 50 && !req_ready; i++) step();
    req_count = CNT_W'(n);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    first_back = servo_ctrl[0];
    pushes = 0; pulses = 0; lat = 0; upper_ok = 1; seen = 0; prev = 0; cyc = 1;
    busy_at_done = 1; ready_at_done = 0;
    while (!seen && cyc < 6000) begin
      if (servo_ctrl[31:1] != 31'd0) upper_ok = 0;
      if (servo_ctrl[0] && !prev) pushes++;
      prev = servo_ctrl[0];
      if (done) begin
        seen = 1; pulses++; lat = cyc;
        busy_at_done = busy; ready_at_done = req_ready;
      end
      if (noise && cyc >= 20 && cyc < 25) begin
        req_valid = 1'b1; req_count = CNT_W'(7);
      end else begin
        req_valid = 1'b0;
      end
      if (!seen) begin step(); cyc++; end
    end
    req_valid = 1'b0;
    timed_out = !seen;
    disp = int'(dispensed);
    err = int'(error);
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) pulses++;
    end
    $display("req n=%0d disp=%0d err=%0d pushes=%0d pulses=%0d lat=%0d", n, disp, err, pushes, pulses, lat);
  endtask

  // Runs one request and checks it against the reference model.
  task automatic test_request(input string name, input int n, input int kind, input int coin,
                              input bit noise);
    int disp, err, pushes, pulses, lat, e_disp, e_err, e_push;
    bit to, uok, fb, bad, rad;
    fault_kind = (kind == 3) ? 0 : kind;
    fault_coin = coin;
`ifdef COIN_ABORT_EN
    abort_coin = (kind == 3) ? coin : 0;
`endif
    ref_model(n, kind, coin, e_disp, e_err, e_push);
    run_req(n, noise, disp, err, pushes, pulses, lat, to, uok, fb, bad, rad);
    total_cnt++;
    if (to !== 1'b0) $display("FAIL %s timeout: got no done pulse, required one", name);
    else pass_cnt++;
    total_cnt++;
    if (disp !== e_disp) $display("FAIL %s dispensed: got %0d required %0d", name, disp, e_disp);
    else pass_cnt++;
    total_cnt++;
    if (err !== e_err) $display("FAIL %s error: got %0d required %0d", name, err, e_err);
    else pass_cnt++;
    total_cnt++;
    if (pushes !== e_push) $display("FAIL %s pushes: got %0d required %0d", name, pushes, e_push);
    else pass_cnt++;
    total_cnt++;
    if (pulses !== 1) $display("FAIL %s done_pulses: got %0d required 1", name, pulses);
    else pass_cnt++;
    total_cnt++;
    if (uok !== 1'b1 || servo_ctrl !== 32'd0)
      $display("FAIL %s servo_ctrl: got %h (upper_ok=%0d) required 0", name, servo_ctrl, uok);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 1'b0 || rad !== 1'b1)
      $display("FAIL %s busy/ready at done: got %0d/%0d required 0/1", name, bad, rad);
    else pass_cnt++;
    total_cnt++;
    if (fb !== (n != 0)) $display("FAIL %s first_ctrl: got %0d required %0d", name, fb, (n != 0));
    else pass_cnt++;
    if (n == 0) begin
      total_cnt++;
      if (lat !== 2) $display("FAIL %s done_latency: got %0d required 2", name, lat);
      else pass_cnt++;
    end
`ifdef COIN_ABORT_EN
    abort_coin = 0;
`endif
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) step();
    total_cnt++;
    if (servo_ctrl !== 32'd0 || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0 || dispensed !== '0)
      $display("FAIL reset_state: got ctrl=%h rdy=%0b busy=%0b done=%0b err=%0b disp=%0d required 0/1/0/0/0/0",
               servo_ctrl, req_ready, busy, done, error, dispensed);
    else pass_cnt++;
    clr = 1'b1;
    recover();
  endtask

  task automatic test_reset_mid();
    bit reached, done_seen;
    req_count = CNT_W'(3);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    reached = 0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      if (back_edges == 2 && bt >= 20) reached = 1;
      else step();
    end
    total_cnt++;
    if (!reached) $display("FAIL reset_mid reach: got no PUSH_WAIT of coin 2, required it");
    else pass_cnt++;
    #2 clr = 1'b0;
    #1;
    total_cnt++;
    if (servo_ctrl !== 32'd0 || req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        error !== 1'b0 || dispensed !== '0)
      $display("FAIL reset_mid state: got ctrl=%h rdy=%0b busy=%0b done=%0b err=%0b disp=%0d required 0/1/0/0/0/0",
               servo_ctrl, req_ready, busy, done, error, dispensed);
    else pass_cnt++;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_seen = 1;
    end
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_seen = 1;
    end
    total_cnt++;
    if (done_seen) $display("FAIL reset_mid done: got a done pulse, required none");
    else pass_cnt++;
    recover();
    test_request("after_reset", 2, 0, 0, 0);
    recover();
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n, kind, coin;
      n    = int'($urandom_range(0, 5));
      kind = int'($urandom_range(0, 2));
      coin = int'($urandom_range(1, 5));
      test_request("random", n, kind, coin, 0);
      recover();
    end
  endtask

  task automatic test_back_to_back();
    test_request("b2b_first", 2, 0, 0, 0);
    test_request("b2b_second", 1, 0, 0, 0);
    recover();
  endtask

  task automatic test_error_clear();
    test_request("err_set", 2, 1, 1, 0);
    recover();
    test_request("err_cleared", 1, 0, 0, 0);
    recover();
  endtask

  initial begin
    test_reset();
    test_request("three_coins", 3, 0, 0, 0);
    recover();
    test_request("zero_count", 0, 0, 0, 0);
    recover();
    test_request("back_no_ack", 2, 1, 1, 0);
    recover();
    test_request("front_stuck", 4, 2, 2, 0);
    recover();
    test_request("ignore_busy", 2, 0, 0, 1);
    recover();
    test_back_to_back();
    test_error_clear();
    test_reset_mid();
    test_random();
`ifdef COIN_ABORT_EN
    test_request("abort", 5, 3, 2, 0);
    recover();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
